// File: rtl/io_pkg.sv
// io_pkg
// Shared definitions for the I/O channel: condition codes returned to the
// CPU, the state encodings of the command and transfer FSMs, the default
// transfer watchdog length, and a saturating word-count helper.
package io_pkg;

    // Condition codes presented on cpu_cc.
    localparam logic [0:3] CC_OK   = 4'd0;
    localparam logic [0:3] CC_BUSY = 4'd6;
    localparam logic [0:3] CC_ERR  = 4'd8;

    // Idle ACTIVE cycles tolerated without a device write.
    localparam int DEFAULT_TIMEOUT = 4096;

    typedef enum logic [1:0] {
        IDLE,
        TIO_ISSUE,
        TIO_WAIT,
        RESP
    } cmd_state_t;

    typedef enum logic {
        XIDLE,
        ACTIVE
    } xfer_state_t;

    // Word counter increment that sticks at all-ones.
    function automatic logic [0:15] sat_inc16(input logic [0:15] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/io_channel_if.sv
// io_channel_if
// Bundles every CPU, device and memory signal of the I/O channel.
//   CPU side    : cpu_sio/cpu_tio command pulses, cpu_cc/cpu_done response,
//                 cpu_mem_req/cpu_mem_grant arbitration, cpu_address/data/
//                 wr_enables memory request.
//   Device side : dev_sio/dev_tio/dev_active strobes, dev_cc status,
//                 dev_address/data/wr_enables memory request.
//   Memory side : mem_address/data/wr_enables steered from CPU or device.
//   Status      : xfer_count (words in current/last transfer), xfer_busy.
// Modport slave is the channel itself; master is its environment (CPU,
// device model and memory).
interface io_channel_if;

    logic         cpu_sio;
    logic         cpu_tio;
    logic [0:3]   cpu_cc;
    logic         cpu_done;
    logic         cpu_mem_req;
    logic         cpu_mem_grant;
    logic [15:31] cpu_address;
    logic [0:31]  cpu_data;
    logic [0:3]   cpu_wr_enables;

    logic         dev_sio;
    logic         dev_tio;
    logic         dev_active;
    logic [0:3]   dev_cc;
    logic [15:31] dev_address;
    logic [0:31]  dev_data;
    logic [0:3]   dev_wr_enables;

    logic [15:31] mem_address;
    logic [0:31]  mem_data;
    logic [0:3]   mem_wr_enables;

    logic [0:15]  xfer_count;
    logic         xfer_busy;

    modport slave (
        input  cpu_sio, cpu_tio, cpu_mem_req,
        input  cpu_address, cpu_data, cpu_wr_enables,
        input  dev_cc, dev_address, dev_data, dev_wr_enables,
        output cpu_cc, cpu_done, cpu_mem_grant,
        output dev_sio, dev_tio, dev_active,
        output mem_address, mem_data, mem_wr_enables,
        output xfer_count, xfer_busy
    );

    modport master (
        output cpu_sio, cpu_tio, cpu_mem_req,
        output cpu_address, cpu_data, cpu_wr_enables,
        output dev_cc, dev_address, dev_data, dev_wr_enables,
        input  cpu_cc, cpu_done, cpu_mem_grant,
        input  dev_sio, dev_tio, dev_active,
        input  mem_address, mem_data, mem_wr_enables,
        input  xfer_count, xfer_busy
    );

endinterface

// File: rtl/io_mem_mux.sv
// io_mem_mux
// Memory port steering. dev_owns is dev_active delayed one cycle: the device
// sees dev_active, then drives its request in the following cycle, which is
// the cycle the memory port is switched to it.
//   clock, reset      : clock, asynchronous active-low reset
//   dev_active        : device granted for the next cycle
//   cpu_* / dev_*     : competing memory requests
//   dev_owns          : device owns the memory port this cycle
//   mem_*             : steered memory request
module io_mem_mux
    import io_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         dev_active,
    input  logic [15:31] cpu_address,
    input  logic [0:31]  cpu_data,
    input  logic [0:3]   cpu_wr_enables,
    input  logic [15:31] dev_address,
    input  logic [0:31]  dev_data,
    input  logic [0:3]   dev_wr_enables,
    output logic         dev_owns,
    output logic [15:31] mem_address,
    output logic [0:31]  mem_data,
    output logic [0:3]   mem_wr_enables
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dev_owns <= 1'b0;
        end else begin
            dev_owns <= dev_active;
        end
    end

    assign mem_address    = dev_owns ? dev_address    : cpu_address;
    assign mem_data       = dev_owns ? dev_data       : cpu_data;
    assign mem_wr_enables = dev_owns ? dev_wr_enables : cpu_wr_enables;

endmodule

// File: rtl/io_channel.sv
// io_channel
// CPU-to-device I/O channel. A command FSM handles SIO (start transfer) and
// TIO (test device) from the CPU; a transfer FSM lets the device write memory
// between CPU accesses until it signals end-of-record (a granted cycle with
// no write enables) or goes silent for TIMEOUT cycles.
//   clock  : single clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : io_channel_if.slave carrying all CPU, device and memory signals
module io_channel
    import io_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    io_channel_if.slave bus
);

    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    cmd_state_t    cmd_state;
    xfer_state_t   xfer_state;
    logic          cpu_done_q;
    logic          dev_sio_q;
    logic          dev_tio_q;
    logic [0:3]    cpu_cc_q;
    logic          dev_active_q;
    logic          timeout_flag;
    logic [0:15]   xfer_count_q;
    logic [IW-1:0] idle_cnt;
    logic          dev_owns;

    logic          dev_write;
    logic          end_of_record;
    logic          timeout_hit;
    logic          sio_accept;
    logic          tio_resp;

    assign dev_write     = dev_owns && (bus.dev_wr_enables != 4'b0000);
    assign end_of_record = (xfer_state == ACTIVE) && dev_owns && !dev_write;
    // A granted cycle always either writes or ends the record, so the
    // watchdog can only fire in cycles the device does not own memory.
    assign timeout_hit   = (xfer_state == ACTIVE) && !dev_owns &&
                           (idle_cnt == IW'(TIMEOUT - 1));
    assign sio_accept    = (cmd_state == IDLE) && bus.cpu_sio && (xfer_state == XIDLE);
    assign tio_resp      = (cmd_state == TIO_WAIT);

    // Command FSM: SIO answers in one cycle; TIO strobes the device, samples
    // dev_cc a cycle later and answers in the cycle after that.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_state  <= IDLE;
            cpu_done_q <= 1'b0;
            dev_sio_q  <= 1'b0;
            dev_tio_q  <= 1'b0;
            cpu_cc_q   <= CC_OK;
        end else begin
            cpu_done_q <= 1'b0;
            dev_sio_q  <= 1'b0;
            dev_tio_q  <= 1'b0;
            case (cmd_state)
                IDLE: begin
                    // SIO wins over a simultaneous TIO, which is dropped.
                    if (bus.cpu_sio) begin
                        cpu_done_q <= 1'b1;
                        cmd_state  <= RESP;
                        if (xfer_state == XIDLE) begin
                            cpu_cc_q  <= CC_OK;
                            dev_sio_q <= 1'b1;
                        end else begin
                            cpu_cc_q  <= CC_BUSY;
                        end
                    end else if (bus.cpu_tio) begin
                        dev_tio_q <= 1'b1;
                        cmd_state <= TIO_ISSUE;
                    end
                end
                TIO_ISSUE: cmd_state <= TIO_WAIT;
                TIO_WAIT: begin
                    cpu_done_q <= 1'b1;
                    cpu_cc_q   <= bus.dev_cc | (timeout_flag ? CC_ERR : CC_OK);
                    cmd_state  <= RESP;
                end
                RESP:    cmd_state <= IDLE;
                default: cmd_state <= IDLE;
            endcase
        end
    end

    // Transfer FSM, device grant, word count and silence watchdog.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xfer_state   <= XIDLE;
            dev_active_q <= 1'b0;
            timeout_flag <= 1'b0;
            xfer_count_q <= '0;
            idle_cnt     <= '0;
        end else begin
            // CPU requests always pre-empt the device.
            dev_active_q <= (xfer_state == ACTIVE) && !bus.cpu_mem_req;

            // Granted-cycle writes may trail the end of the transfer by a
            // couple of cycles; they still count until the next SIO clears.
            if (sio_accept) begin
                xfer_count_q <= '0;
            end else if (dev_write) begin
                xfer_count_q <= sat_inc16(xfer_count_q);
            end

            // A new abort outranks a clear landing on the same edge.
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end else if (sio_accept || tio_resp) begin
                timeout_flag <= 1'b0;
            end

            if ((xfer_state != ACTIVE) || dev_write || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IW'(1);
            end

            case (xfer_state)
                XIDLE: begin
                    if (sio_accept) begin
                        xfer_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (end_of_record || timeout_hit) begin
                        xfer_state <= XIDLE;
                    end
                end
                default: xfer_state <= XIDLE;
            endcase
        end
    end

    io_mem_mux u_mem_mux (
        .clock          (clock),
        .reset          (reset),
        .dev_active     (dev_active_q),
        .cpu_address    (bus.cpu_address),
        .cpu_data       (bus.cpu_data),
        .cpu_wr_enables (bus.cpu_wr_enables),
        .dev_address    (bus.dev_address),
        .dev_data       (bus.dev_data),
        .dev_wr_enables (bus.dev_wr_enables),
        .dev_owns       (dev_owns),
        .mem_address    (bus.mem_address),
        .mem_data       (bus.mem_data),
        .mem_wr_enables (bus.mem_wr_enables)
    );

    assign bus.cpu_cc        = cpu_cc_q;
    assign bus.cpu_done      = cpu_done_q;
    assign bus.dev_sio       = dev_sio_q;
    assign bus.dev_tio       = dev_tio_q;
    assign bus.dev_active    = dev_active_q;
    assign bus.cpu_mem_grant = !dev_owns;
    assign bus.xfer_count    = xfer_count_q;
    assign bus.xfer_busy     = (xfer_state == ACTIVE);

endmodule

// File: tb/tb_io_channel.sv
// tb_io_channel
// Directed bench for io_channel (TIMEOUT=16). A cycle-level reference model
// built from event timestamps predicts every output; a compare process
// checks it on each falling edge, and the directed sequences add literal
// expectations at the interesting cycles.
module tb_io_channel;
    import io_pkg::*;

    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    io_channel_if bus ();

    io_channel #(.TIMEOUT(TMO)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- device / CPU bus driver ----------------
    int dev_words = 0;
    int drv_seq   = 0;
    bit drv_prev  = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            drv_seq++;
            bus.cpu_address    = 17'(drv_seq * 7);
            bus.cpu_data       = 32'h1000_0000 + 32'(drv_seq);
            bus.cpu_wr_enables = 4'(drv_seq);
            bus.dev_address    = 17'(drv_seq * 13 + 5);
            bus.dev_data       = 32'hA500_0000 ^ 32'(drv_seq);
            // The device owns memory the cycle after it saw dev_active.
            if (drv_prev && dev_words > 0) begin
                bus.dev_wr_enables = (drv_seq % 3 == 0) ? 4'h1 : 4'hF;
                dev_words--;
            end else begin
                bus.dev_wr_enables = 4'h0;
            end
            drv_prev = bus.dev_active;
        end
    end

    // ---------------- reference model ----------------
    int         m_c = 0;
    bit         m_busy;
    int         m_cnt;
    int         m_ref;
    bit         m_tflag;
    int         m_cmd_free;
    int         m_cap;
    bit         m_e_done, m_e_sio, m_e_tio, m_e_active, m_e_owns;
    logic [3:0] m_e_cc;

    initial begin
        bit         wr, nb, n_done, n_sio, n_tio, n_active, n_owns, set_flag;
        int         ncnt;
        logic [3:0] n_cc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_cnt = 0; m_ref = 0; m_tflag = 0;
                m_cmd_free = m_c; m_cap = -1;
                m_e_done = 0; m_e_sio = 0; m_e_tio = 0; m_e_active = 0; m_e_owns = 0;
                m_e_cc = 4'h0;
            end else begin
                check("cpu_done",   32'(bus.cpu_done),   32'(m_e_done));
                check("cpu_cc",     32'(bus.cpu_cc),     32'(m_e_cc));
                check("dev_sio",    32'(bus.dev_sio),    32'(m_e_sio));
                check("dev_tio",    32'(bus.dev_tio),    32'(m_e_tio));
                check("dev_active", 32'(bus.dev_active), 32'(m_e_active));
                check("mem_grant",  32'(bus.cpu_mem_grant), 32'(!m_e_owns));
                check("xfer_busy",  32'(bus.xfer_busy),  32'(m_busy));
                check("xfer_count", 32'(bus.xfer_count), 32'(m_cnt));
                check("mem_address", 32'(bus.mem_address),
                      32'(m_e_owns ? bus.dev_address : bus.cpu_address));
                check("mem_data", 32'(bus.mem_data),
                      32'(m_e_owns ? bus.dev_data : bus.cpu_data));
                check("mem_wr_enables", 32'(bus.mem_wr_enables),
                      32'(m_e_owns ? bus.dev_wr_enables : bus.cpu_wr_enables));

                // Expectations for the next cycle.
                wr       = m_e_owns && (bus.dev_wr_enables != 4'h0);
                nb       = m_busy;
                ncnt     = m_cnt;
                n_done   = 0; n_sio = 0; n_tio = 0; set_flag = 0;
                n_cc     = m_e_cc;
                n_active = m_busy && !bus.cpu_mem_req;
                n_owns   = m_e_active;
                if (wr) begin
                    ncnt  = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
                    m_ref = m_c;
                end
                if (m_busy) begin
                    if (m_e_owns && !wr) nb = 0;
                    else if ((m_c - m_ref) == TMO) begin
                        nb = 0;
                        set_flag = 1;
                    end
                end
                if (m_c == m_cap) begin
                    n_done  = 1;
                    n_cc    = bus.dev_cc | (m_tflag ? 4'h8 : 4'h0);
                    m_tflag = 0;
                end
                if (set_flag) m_tflag = 1;
                if (m_c >= m_cmd_free) begin
                    if (bus.cpu_sio) begin
                        n_done     = 1;
                        m_cmd_free = m_c + 2;
                        if (m_busy) begin
                            n_cc = 4'h6;
                        end else begin
                            n_cc = 4'h0; n_sio = 1; nb = 1; ncnt = 0;
                            m_ref = m_c; m_tflag = 0;
                        end
                    end else if (bus.cpu_tio) begin
                        n_tio      = 1;
                        m_cap      = m_c + 2;
                        m_cmd_free = m_c + 4;
                    end
                end
                m_busy = nb; m_cnt = ncnt;
                m_e_done = n_done; m_e_cc = n_cc; m_e_sio = n_sio; m_e_tio = n_tio;
                m_e_active = n_active; m_e_owns = n_owns;
                m_c++;
            end
        end
    end

    // ---------------- directed sequences ----------------
    task automatic pulse_sio(input logic [3:0] exp_cc, input bit exp_sio);
        bus.cpu_sio = 1'b1;
        tick(1);
        bus.cpu_sio = 1'b0;
        check("sio_done", 32'(bus.cpu_done), 32'd1);
        check("sio_cc",   32'(bus.cpu_cc),   32'(exp_cc));
        check("sio_dev_sio", 32'(bus.dev_sio), 32'(exp_sio));
        tick(1);
    endtask

    task automatic pulse_tio(input logic [3:0] dev_code, input logic [3:0] exp_cc);
        bus.dev_cc  = dev_code;
        bus.cpu_tio = 1'b1;
        tick(1);
        bus.cpu_tio = 1'b0;
        check("tio_dev_tio_k1", 32'(bus.dev_tio), 32'd1);
        tick(1);
        check("tio_done_k2", 32'(bus.cpu_done), 32'd0);
        tick(1);
        check("tio_done_k3", 32'(bus.cpu_done), 32'd1);
        check("tio_cc_k3",   32'(bus.cpu_cc),   32'(exp_cc));
        tick(1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.xfer_busy && n < 300) begin
            tick(1);
            n++;
        end
        check({name, "_idle"}, 32'(bus.xfer_busy), 32'd0);
    endtask

    initial begin
        int n;
        bus.cpu_sio = 0; bus.cpu_tio = 0; bus.cpu_mem_req = 0;
        bus.cpu_address = '0; bus.cpu_data = '0; bus.cpu_wr_enables = '0;
        bus.dev_cc = '0; bus.dev_address = '0; bus.dev_data = '0; bus.dev_wr_enables = '0;

        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("rst_cc",    32'(bus.cpu_cc),        32'd0);
        check("rst_grant", 32'(bus.cpu_mem_grant), 32'd1);
        check("rst_count", 32'(bus.xfer_count),    32'd0);

        // SIO from idle, 30-word transfer.
        dev_words = 30;
        pulse_sio(4'h0, 1'b1);
        wait_idle("xfer30");
        check("xfer30_count", 32'(bus.xfer_count), 32'd30);
        tick(4);

        // Second SIO mid-transfer, then a 10-cycle CPU hold.
        dev_words = 20;
        pulse_sio(4'h0, 1'b1);
        tick(5);
        pulse_sio(4'h6, 1'b0);
        bus.cpu_mem_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("hold_dev_active", 32'(bus.dev_active), 32'd0);
            if (i >= 1) check("hold_grant", 32'(bus.cpu_mem_grant), 32'd1);
        end
        bus.cpu_mem_req = 1'b0;
        check("hold_still_busy", 32'(bus.xfer_busy), 32'd1);
        wait_idle("xfer20");
        check("xfer20_count", 32'(bus.xfer_count), 32'd20);
        tick(4);

        // TIO responses.
        pulse_tio(4'h0, 4'h0);
        pulse_tio(4'h5, 4'h5);

        // Simultaneous SIO+TIO: only the SIO is answered.
        dev_words = 0;
        bus.cpu_sio = 1'b1;
        bus.cpu_tio = 1'b1;
        tick(1);
        bus.cpu_sio = 1'b0;
        bus.cpu_tio = 1'b0;
        check("both_done",    32'(bus.cpu_done), 32'd1);
        check("both_dev_sio", 32'(bus.dev_sio),  32'd1);
        check("both_dev_tio", 32'(bus.dev_tio),  32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("both_no_tio",  32'(bus.dev_tio),  32'd0);
            check("both_no_done", 32'(bus.cpu_done), 32'd0);
        end
        wait_idle("both");
        tick(4);

        // Silent device (CPU holds memory): watchdog abort after 16 cycles.
        bus.cpu_mem_req = 1'b1;
        tick(1);
        bus.cpu_sio = 1'b1;
        tick(1);
        bus.cpu_sio = 1'b0;
        n = 0;
        while (bus.xfer_busy && n < 100) begin
            tick(1);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd16);
        bus.cpu_mem_req = 1'b0;
        tick(2);
        pulse_tio(4'h0, 4'h8);
        pulse_tio(4'h3, 4'h3);
        tick(2);

        // Reset mid-transfer.
        dev_words = 20;
        pulse_sio(4'h0, 1'b1);
        tick(6);
        #2;
        rst_n = 1'b0;
        #1;
        dev_words = 0;
        check("arst_busy",   32'(bus.xfer_busy),     32'd0);
        check("arst_count",  32'(bus.xfer_count),    32'd0);
        check("arst_active", 32'(bus.dev_active),    32'd0);
        check("arst_grant",  32'(bus.cpu_mem_grant), 32'd1);
        check("arst_done",   32'(bus.cpu_done),      32'd0);
        check("arst_cc",     32'(bus.cpu_cc),        32'd0);
        check("arst_sio",    32'(bus.dev_sio),       32'd0);
        check("arst_tio",    32'(bus.dev_tio),       32'd0);
        check("arst_mem",    32'(bus.mem_address),   32'(bus.cpu_address));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
        pulse_sio(4'h0, 1'b1);
        wait_idle("post_reset");
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
